// File: rtl/test_io_pkg.sv
// Shared constants and FSM encoding for the test I/O packet decoder:
// opcodes, header status codes, sync byte and a saturating counter helper.
package test_io_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_ILLEGAL = 8'h01;
  localparam logic [7:0] ST_CHKSUM  = 8'h02;
  localparam logic [7:0] ST_RSP_ERR = 8'h03;
  localparam logic [7:0] ST_TIMEOUT = 8'h04;

  localparam logic [7:0] SYNC_BYTE = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    SEND_HDR,
    SEND_DATA
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/test_io_pkt_dec.sv
// Decodes 4-word host packets into single memory requests and returns a
// header word (plus read data for successful reads) to the host.
module test_io_pkt_dec
  import test_io_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pkt_valid,
  output logic                    pkt_ready,
  input  logic [4*DATA_WIDTH-1:0] pkt_data,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_we,
  output logic [31:0]             req_addr,
  output logic [31:0]             req_wdata,
  output logic [3:0]              req_be,
  input  logic                    rsp_valid,
  output logic                    rsp_ready,
  input  logic [31:0]             rsp_rdata,
  input  logic                    rsp_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_data,
  output logic [15:0]             pkt_cnt,
  output logic [15:0]             err_cnt
);

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  state_t state_reg, state_next;

  logic [7:0]  timer_reg, timer_next;
  logic [15:0] pkt_cnt_reg, err_cnt_reg;

  // Payload registers carry no reset; the FSM never looks at them before a load.
  logic [7:0]  opcode_reg, tag_reg, status_reg, status_next;
  logic [3:0]  be_reg;
  logic [31:0] addr_reg, wdata_reg, rdata_reg;

  logic load_pkt, load_rdata, hdr_done;

  logic [31:0] w0, w1, w2, w3;
  logic        chksum_ok;
  logic [7:0]  in_opcode;
  logic [7:0]  timer_inc;

  assign w0 = pkt_data[0*DATA_WIDTH +: 32];
  assign w1 = pkt_data[1*DATA_WIDTH +: 32];
  assign w2 = pkt_data[2*DATA_WIDTH +: 32];
  assign w3 = pkt_data[3*DATA_WIDTH +: 32];

  assign chksum_ok = (w3 == (w0 ^ w1 ^ w2));
  assign in_opcode = w0[7:0];
  assign timer_inc = timer_reg + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      timer_reg   <= 8'd0;
      pkt_cnt_reg <= 16'd0;
      err_cnt_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      if (load_pkt) begin
        pkt_cnt_reg <= sat_inc16(pkt_cnt_reg);
      end
      if (hdr_done && (status_reg != ST_OK)) begin
        err_cnt_reg <= sat_inc16(err_cnt_reg);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_pkt) begin
      opcode_reg <= w0[7:0];
      tag_reg    <= w0[15:8];
      be_reg     <= w0[19:16];
      addr_reg   <= w1;
      wdata_reg  <= w2;
    end
    if (load_rdata) begin
      rdata_reg <= rsp_rdata;
    end
    status_reg <= status_next;
  end

  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    status_next = status_reg;
    load_pkt    = 1'b0;
    load_rdata  = 1'b0;
    hdr_done    = 1'b0;
    pkt_ready   = 1'b0;
    rsp_ready   = 1'b0;
    req_valid   = 1'b0;
    out_valid   = 1'b0;
    out_data    = {SYNC_BYTE, opcode_reg, tag_reg, status_reg};

    case (state_reg)
      IDLE: begin
        pkt_ready = 1'b1;
        // Stray responses arriving here are accepted and dropped.
        rsp_ready = 1'b1;
        if (pkt_valid) begin
          load_pkt = 1'b1;
          if (!chksum_ok) begin
            status_next = ST_CHKSUM;
            state_next  = SEND_HDR;
          end else if (in_opcode == OP_NOP) begin
            status_next = ST_OK;
            state_next  = SEND_HDR;
          end else if ((in_opcode == OP_WRITE) || (in_opcode == OP_READ)) begin
            state_next = ISSUE;
          end else begin
            status_next = ST_ILLEGAL;
            state_next  = SEND_HDR;
          end
        end
      end

      ISSUE: begin
        req_valid = 1'b1;
        if (req_ready) begin
          timer_next = 8'd0;
          state_next = WAIT;
        end
      end

      WAIT: begin
        rsp_ready  = 1'b1;
        timer_next = timer_inc;
        // A response landing on the timeout cycle still wins.
        if (rsp_valid) begin
          load_rdata  = 1'b1;
          status_next = rsp_err ? ST_RSP_ERR : ST_OK;
          state_next  = SEND_HDR;
        end else if (timer_inc == TIMEOUT_CNT) begin
          status_next = ST_TIMEOUT;
          state_next  = SEND_HDR;
        end
      end

      SEND_HDR: begin
        out_valid = 1'b1;
        if (out_ready) begin
          hdr_done = 1'b1;
          if ((opcode_reg == OP_READ) && (status_reg == ST_OK)) begin
            state_next = SEND_DATA;
          end else begin
            state_next = IDLE;
          end
        end
      end

      SEND_DATA: begin
        out_valid = 1'b1;
        out_data  = rdata_reg;
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign req_we    = (opcode_reg == OP_WRITE);
  assign req_addr  = addr_reg;
  assign req_wdata = req_we ? wdata_reg : 32'd0;
  assign req_be    = be_reg;
  assign pkt_cnt   = pkt_cnt_reg;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: doc/test_io_pkt_dec.md
TEST_IO_PKT_DEC -- requirements
Module: test_io_pkt_dec

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width; only 32 is supported.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum memory-response wait in cycles; range 1..255.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports pkt_valid (input, 1) and pkt_ready (output, 1): packet handshake from the 4-word collector.
REQ-006 SHALL have port pkt_data, input, 4*DATA_WIDTH: word i is pkt_data[i*32 +: 32].
REQ-007 SHALL have ports req_valid (output, 1), req_ready (input, 1), req_we (output, 1), req_addr (output, 32), req_wdata (output, 32), req_be (output, 4): the memory request.
REQ-008 SHALL have ports rsp_valid (input, 1), rsp_ready (output, 1), rsp_rdata (input, 32), rsp_err (input, 1): the memory response.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 32): the host response word stream.
REQ-010 SHALL have ports pkt_cnt (output, 16) and err_cnt (output, 16): saturating statistics.

Function
REQ-011 SHALL decode packet words as: W0[7:0] opcode, W0[15:8] tag, W0[19:16] byte enables; W1 address; W2 write data; W3 checksum.
REQ-012 SHALL define opcodes: NOP=0x00, WRITE=0x01, READ=0x02; any other value is illegal.
REQ-013 SHALL accept a packet as valid only when W3 == W0^W1^W2.
REQ-014 SHALL use FSM states IDLE, ISSUE, WAIT, SEND_HDR, SEND_DATA.
REQ-015 SHALL assert pkt_ready only in IDLE; on pkt_valid&pkt_ready it SHALL register W0..W2 and increment pkt_cnt.
REQ-016 SHALL, when the checksum is bad, go from IDLE to SEND_HDR with status 0x02; a bad checksum takes precedence over an illegal opcode.
REQ-017 SHALL, for an illegal opcode, go from IDLE to SEND_HDR with status 0x01.
REQ-018 SHALL, for NOP, go from IDLE to SEND_HDR with status 0x00.
REQ-019 SHALL, for WRITE or READ, go from IDLE to ISSUE, so that req_valid rises the cycle after packet acceptance.
REQ-020 SHALL drive req_valid and hold req_* stable in ISSUE until req_ready, then go to WAIT.
REQ-021 SHALL drive req_we=1 for WRITE; for READ it SHALL drive req_we=0 and req_wdata=0.
REQ-022 SHALL assert rsp_ready in WAIT and in IDLE; responses received in IDLE are discarded.
REQ-023 SHALL, in WAIT, on rsp_valid: capture rsp_rdata, set status to 0x03 if rsp_err else 0x00, and go to SEND_HDR.
REQ-024 SHALL count WAIT cycles with an 8-bit counter that is cleared on entering WAIT.
REQ-025 SHALL, when the WAIT counter reaches TIMEOUT with no rsp_valid, set status 0x04 and go to SEND_HDR.
REQ-026 SHALL give rsp_valid priority over timeout when both occur in the same cycle.
REQ-027 SHALL, in SEND_HDR, drive out_valid with out_data = {8'h5A, opcode, tag, status}.
REQ-028 SHALL, on out_ready in SEND_HDR, go to SEND_DATA for READ with status 0x00, and to IDLE otherwise.
REQ-029 SHALL, in SEND_DATA, drive out_data = captured rdata and return to IDLE on out_ready.
REQ-030 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-031 SHALL increment err_cnt on each header sent with status != 0.
REQ-032 SHALL saturate pkt_cnt and err_cnt at 0xFFFF.

Reset
REQ-033 SHALL, on rst=1 at a clk edge, force state=IDLE, req_valid=0, out_valid=0, both counters=0, and the timeout counter=0.
REQ-034 SHALL have pkt_ready=1 and rsp_ready=1 in the first cycle after reset.
REQ-035 SHALL abandon any in-flight transaction when rst is asserted mid-operation; no response word is emitted for it.
REQ-036 SHALL leave the data registers unreset.

Structure
REQ-037 SHALL take the opcode constants, status codes (0x00-0x04), sync byte 0x5A and FSM state enum from shared package test_io_pkg.
REQ-038 SHALL be a single module with no sub-modules.

Verification
REQ-039 SHALL cover WRITE: W0=0x000F2A01, W1=0x00001000, W2=0xDEADBEEF, W3=0xDEA284EE, then rsp_valid with rsp_err=0 -> one req with we=1, be=0xF; out_data=0x5A012A00.
REQ-040 SHALL cover READ: W0=0x00000702, W1=0x00002000, W2=0, W3=0x00002702, then rsp_rdata=0x12345678 -> out words 0x5A020700 then 0x12345678.
REQ-041 SHALL cover bad checksum: the WRITE packet of REQ-039 with W3=0 -> no req_valid; out_data=0x5A012A02; err_cnt=1.
REQ-042 SHALL cover illegal opcode: W0=0x00001109 with a correct checksum -> no req_valid; out_data=0x5A091101.
REQ-043 SHALL cover timeout: the READ of REQ-040 with no rsp_valid -> exactly 255 WAIT cycles, then the single word 0x5A020704.
REQ-044 SHALL cover reset in WAIT plus out_ready backpressure: out_valid stays 0, pkt_ready=1 the next cycle; with out_ready held low 10 cycles, out_data is stable.
